// File: rtl/decodificador_johnson.sv
// Decoder for a 6-bit Johnson counter: phase 0..11, lock/sequence checking, revolution count.
// One-cycle latency, all outputs registered; no backpressure. Define DECODIFICADOR_JOHNSON_VOLTAS_EN to build the revolution counter.
module decodificador_johnson #(
    parameter int LARGURA_VOLTAS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [5:0]                entrada_q,
    input  logic                      limpar_erro,
    output logic [3:0]                fase,
    output logic                      valido,
    output logic                      erro_seq,
    output logic [LARGURA_VOLTAS-1:0] voltas,
    output logic                      pulso_volta
);

    typedef enum logic [1:0] {
        SINC    = 2'd0,
        TRAVADO = 2'd1,
        FALHA   = 2'd2
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [3:0] fase_q, fase_d;
    logic       valido_q, valido_d;
    logic       erro_q, erro_d;
    logic [5:0] prev_q, prev_d;

    function automatic logic codigo_legal(input logic [5:0] c);
        case (c)
            6'b000000, 6'b000001, 6'b000011, 6'b000111,
            6'b001111, 6'b011111, 6'b111111, 6'b111110,
            6'b111100, 6'b111000, 6'b110000, 6'b100000: codigo_legal = 1'b1;
            default:                                    codigo_legal = 1'b0;
        endcase
    endfunction

    // Rising half of the ring counts ones, falling half counts down from 12.
    function automatic logic [3:0] decodifica(input logic [5:0] c);
        logic [3:0] pop;
        pop = 4'(c[0]) + 4'(c[1]) + 4'(c[2]) + 4'(c[3]) + 4'(c[4]) + 4'(c[5]);
        decodifica = c[5] ? (4'd12 - pop) : pop;
    endfunction

    function automatic logic [5:0] sucessor(input logic [5:0] c);
        sucessor = {c[4:0], ~c[5]};
    endfunction

    always_comb begin
        estado_d = estado_q;
        fase_d   = fase_q;
        valido_d = valido_q;
        erro_d   = erro_q;
        prev_d   = prev_q;
        case (estado_q)
            SINC: begin
                erro_d = 1'b0;
                if (codigo_legal(entrada_q)) begin
                    estado_d = TRAVADO;
                    valido_d = 1'b1;
                    fase_d   = decodifica(entrada_q);
                    prev_d   = entrada_q;
                end else begin
                    valido_d = 1'b0;
                end
            end
            TRAVADO: begin
                if (entrada_q == prev_q) begin
                    estado_d = TRAVADO;
                end else if (entrada_q == sucessor(prev_q)) begin
                    fase_d = decodifica(entrada_q);
                    prev_d = entrada_q;
                end else begin
                    estado_d = FALHA;
                    valido_d = 1'b0;
                    erro_d   = 1'b1;
                end
            end
            FALHA: begin
                valido_d = 1'b0;
                // The code presented alongside the clear is deliberately ignored.
                if (limpar_erro) begin
                    estado_d = SINC;
                    erro_d   = 1'b0;
                end
            end
            default: begin
                estado_d = SINC;
                valido_d = 1'b0;
                erro_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= SINC;
            fase_q   <= 4'd0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
            prev_q   <= 6'b000000;
        end else begin
            estado_q <= estado_d;
            fase_q   <= fase_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
            prev_q   <= prev_d;
        end
    end

    assign fase     = fase_q;
    assign valido   = valido_q;
    assign erro_seq = erro_q;

`ifdef DECODIFICADOR_JOHNSON_VOLTAS_EN
    logic                      volta_completa;
    logic [LARGURA_VOLTAS-1:0] voltas_q, voltas_d;
    logic                      pulso_q, pulso_d;

    // Only a locked 100000 -> 000000 step closes a revolution; relocking at 000000 does not.
    always_comb begin
        volta_completa = (estado_q == TRAVADO) && (prev_q == 6'b100000) &&
                         (entrada_q == 6'b000000);
        voltas_d       = volta_completa ? (voltas_q + 1'b1) : voltas_q;
        pulso_d        = volta_completa;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            voltas_q <= '0;
            pulso_q  <= 1'b0;
        end else begin
            voltas_q <= voltas_d;
            pulso_q  <= pulso_d;
        end
    end

    assign voltas      = voltas_q;
    assign pulso_volta = pulso_q;
`else
    assign voltas      = '0;
    assign pulso_volta = 1'b0;
`endif

endmodule
